// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl
//    Request/response front end for one port of the single-port RW SRAM macro.
//    A client issues valid/ready read and write requests. Each accepted request
//    drives the macro pins in the same cycle. Read data from the macro is
//    captured one cycle later into a small first-word-fall-through response FIFO.
//
// Ports
//    clk0       clock, shared with the macro
//    rst0_n     asynchronous active-low reset
//    req_valid  request valid
//    req_ready  request accepted when req_valid && req_ready at posedge clk0
//    req_we     1 = write, 0 = read
//    req_addr   word address
//    req_wdata  write data
//    rsp_valid  read response valid
//    rsp_ready  client accepts response
//    rsp_rdata  read data (head of response FIFO)
//    csb0       macro chip select, active low
//    web0       macro write enable, active low
//    addr0      macro address
//    din0       macro write data
//    dout0      macro read data
module sram_port_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 7,
   parameter int RSP_DEPTH  = 3
) (
   input  logic                  clk0,
   input  logic                  rst0_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  csb0,
   output logic                  web0,
   output logic [ADDR_WIDTH-1:0] addr0,
   output logic [DATA_WIDTH-1:0] din0,
   input  logic [DATA_WIDTH-1:0] dout0
);

   localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CW = $clog2(RSP_DEPTH + 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(RSP_DEPTH - 1);
   localparam logic [CW:0]   DEPTH_C  = (CW+1)'(RSP_DEPTH);
   localparam logic [CW-1:0] FULL_C   = CW'(RSP_DEPTH);

   logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic                  rd_inflight;
   logic                  fire;
   logic                  push;
   logic                  pop;
   logic [CW:0]           credit_used;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // A read in flight already owns a FIFO slot, so it counts against the
   // credit. This keeps req_ready purely a function of registered state.
   assign credit_used = {1'b0, count} + {{CW{1'b0}}, rd_inflight};
   assign req_ready   = rst0_n && (credit_used < DEPTH_C);
   assign fire        = req_valid && req_ready;

   // req_ready is low in reset, so csb0 is held high while rst0_n is low.
   assign csb0  = !fire;
   assign web0  = !req_we;
   assign addr0 = req_addr;
   assign din0  = req_wdata;

   // dout0 is only meaningful on the edge after a read fire.
   assign push      = rd_inflight;
   assign rsp_valid = (count != '0);
   assign pop       = rsp_valid && rsp_ready;
   assign rsp_rdata = fifo_mem[rd_ptr];

   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         rd_inflight <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         for (int i = 0; i < RSP_DEPTH; i++) begin
            fifo_mem[i] <= '0;
         end
      end else begin
         rd_inflight <= fire && !req_we;
         if (push) begin
            fifo_mem[wr_ptr] <= dout0;
            wr_ptr           <= next_ptr(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clk0) disable iff (!rst0_n)
      !(push && count == FULL_C));

endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb_sram_port_ctrl
//    Directed bench for sram_port_ctrl. It has a behavioural SRAM macro: the pins
//    are sampled at posedge, and the write or read happens at the following negedge.
//    A negedge monitor keeps a reference memory and an expected-response queue.
module tb_sram_port_ctrl;

   localparam int DW = 8;
   localparam int AW = 7;
   localparam int RSP_DEPTH = 3;

   logic          clk0 = 1'b0;
   logic          rst0_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic          csb0;
   logic          web0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] din0;
   logic [DW-1:0] dout0 = '0;

   int n_chk  = 0;
   int n_fail = 0;
   int n_rsp  = 0;
   int stalls = 0;
   int max_occ = 0;
   int exp_infl = 0;
   bit rand_en = 1'b0;
   logic [DW-1:0] ref_mem [128];
   logic [DW-1:0] sram [128];
   logic [DW-1:0] exp_q [$];

   sram_port_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(RSP_DEPTH)) dut (
      .clk0      (clk0),
      .rst0_n    (rst0_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .csb0      (csb0),
      .web0      (web0),
      .addr0     (addr0),
      .din0      (din0),
      .dout0     (dout0)
   );

   always #5 clk0 = ~clk0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // macro model
   logic          m_cs, m_we;
   logic [AW-1:0] m_a;
   logic [DW-1:0] m_d;
   always @(posedge clk0) begin
      m_cs <= !csb0;
      m_we <= !web0;
      m_a  <= addr0;
      m_d  <= din0;
   end
   always @(negedge clk0) begin
      if (m_cs && m_we) begin
         sram[m_a] = m_d;
         dout0 = 8'hxx;
      end else if (m_cs) begin
         dout0 = sram[m_a];
      end else begin
         dout0 = 8'hxx;
      end
   end

   // reference monitor: inputs are stable at negedge for the coming posedge
   always @(negedge clk0) begin
      int  occ;
      bit  fire_rd;
      if (!rst0_n) begin
         exp_q.delete();
         exp_infl = 0;
         chk("rst_req_ready", req_ready, 0);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_rsp_rdata", rsp_rdata, 0);
         chk("rst_csb0", csb0, 1);
      end else begin
         occ = exp_q.size();
         chk("req_ready", req_ready, occ < RSP_DEPTH);
         chk("rsp_valid", rsp_valid, (occ - exp_infl) > 0);
         chk("csb0", csb0, !(req_valid && req_ready));
         if (req_valid && req_ready) begin
            chk("web0", web0, !req_we);
            chk("addr0", addr0, req_addr);
            if (req_we) chk("din0", din0, req_wdata);
         end
         if (rsp_valid && rsp_ready) begin
            n_rsp++;
            if (exp_q.size() == 0) chk("rsp_extra", 1, 0);
            else chk("rsp_data", rsp_rdata, exp_q.pop_front());
         end
         fire_rd = req_valid && req_ready && !req_we;
         if (req_valid && req_ready && req_we) ref_mem[req_addr] = req_wdata;
         if (fire_rd) exp_q.push_back(ref_mem[req_addr]);
         exp_infl = fire_rd ? 1 : 0;
         if (exp_q.size() > max_occ) max_occ = exp_q.size();
      end
   end

   always @(posedge clk0) begin
      if (rand_en) begin
         #1;
         rsp_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic step();
      @(posedge clk0);
      #1;
   endtask

   // Drive a request and return just after the edge on which it fired.
   task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      while (!req_ready && n < 200) begin
         step();
         n++;
      end
      if (n > 0) stalls++;
      if (n >= 200) chk("issue_timeout", 1, 0);
      step();
      req_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      rsp_ready = 1'b1;
      repeat (6) step();
      chk(tag, exp_q.size(), 0);
   endtask

   initial begin
      int base;
      for (int i = 0; i < 128; i++) begin
         ref_mem[i] = '0;
         sram[i]    = '0;
      end
      repeat (3) step();
      rst0_n = 1'b1;
      #1;
      chk("t1_ready_after_rst", req_ready, 1);

      // 1: write then read, one-cycle latency
      issue(1'b1, 7'h05, 8'hA5);
      chk("t1_no_wr_rsp", rsp_valid, 0);
      issue(1'b0, 7'h05, 8'h00);
      chk("t1_lat0", rsp_valid, 0);
      step();
      chk("t1_valid", rsp_valid, 1);
      chk("t1_data", rsp_rdata, 8'hA5);
      drain("t1_drained");

      // 2: fill memory, back-to-back reads
      for (int i = 0; i < 128; i++) issue(1'b1, AW'(i), DW'(i) ^ 8'h3C);
      stalls = 0;
      base = n_rsp;
      for (int i = 0; i < 128; i++) issue(1'b0, AW'(i), 8'h00);
      chk("t2_no_stall", stalls, 0);
      drain("t2_drained");
      chk("t2_rsp_cnt", n_rsp - base, 128);

      // 3: backpressure limits acceptance to the FIFO depth
      rsp_ready = 1'b0;
      base = n_rsp;
      for (int i = 0; i < 3; i++) issue(1'b0, AW'(8'h10 + i), 8'h00);
      chk("t3_ready_low", req_ready, 0);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 7'h13;
      repeat (3) step();
      chk("t3_still_low", req_ready, 0);
      chk("t3_head", rsp_rdata, 8'h2C);
      rsp_ready = 1'b1;
      issue(1'b0, 7'h13, 8'h00);
      issue(1'b0, 7'h14, 8'h00);
      drain("t3_drained");
      chk("t3_rsp_cnt", n_rsp - base, 5);

      // 4: write then read the same address on consecutive cycles
      rsp_ready = 1'b0;
      issue(1'b1, 7'h7F, 8'hFF);
      issue(1'b0, 7'h7F, 8'h00);
      chk("t4_no_wr_rsp", rsp_valid, 0);
      step();
      chk("t4_valid", rsp_valid, 1);
      chk("t4_data", rsp_rdata, 8'hFF);
      drain("t4_drained");

      // 5: reset with two buffered and one in flight
      rsp_ready = 1'b0;
      issue(1'b0, 7'h20, 8'h00);
      issue(1'b0, 7'h21, 8'h00);
      issue(1'b0, 7'h22, 8'h00);
      chk("t5_buffered", rsp_valid, 1);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 7'h23;
      rst0_n = 1'b0;
      #1;
      chk("t5_valid_low", rsp_valid, 0);
      chk("t5_csb0_high", csb0, 1);
      chk("t5_ready_low", req_ready, 0);
      step();
      step();
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      rst0_n = 1'b1;
      base = n_rsp;
      #1;
      chk("t5_ready_after", req_ready, 1);
      repeat (4) step();
      chk("t5_no_stale", n_rsp - base, 0);
      chk("t5_valid_after", rsp_valid, 0);

      // 6: alternating write/read with random backpressure
      max_occ = 0;
      rand_en = 1'b1;
      for (int i = 0; i < 700; i++) begin
         issue(1'b1, AW'($urandom_range(0, 127)), DW'($urandom_range(0, 255)));
         issue(1'b0, AW'($urandom_range(0, 127)), 8'h00);
      end
      rand_en = 1'b0;
      step();
      drain("t6_drained");
      chk("t6_max_occ", max_occ <= RSP_DEPTH, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail + 1);
      $fatal(1);
   end

endmodule
